// File: rtl/mux_4x1_rr.sv
// mux_4x1_rr: round-robin combiner of four valid/ready lanes onto one registered, lane-tagged stream
// Ports: clk/rst (sync, active-high); in_valid[3:0], in_ready[3:0], in0..in3 lane data;
//        out_valid, out_ready, out (registered data), sel (registered source lane index)
module mux_4x1_rr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       sel
);
    logic [1:0]       r_ptr;
    logic             r_valid;
    logic [WIDTH-1:0] r_out;
    logic [1:0]       r_sel;
    logic [1:0]       w_grant;
    logic [1:0]       w_idx;
    logic             w_any;
    logic             w_load;
    logic             w_xfer;
    logic [WIDTH-1:0] w_data;

    // Walk from the farthest offset back to ptr so the lane closest to ptr wins.
    always_comb begin
        w_any   = 1'b0;
        w_grant = r_ptr;
        w_idx   = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (in_valid[w_idx]) begin
                w_any   = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    assign w_load   = !rst && (!r_valid || out_ready);
    assign w_xfer   = w_load && w_any;
    assign in_ready = w_xfer ? 4'b0001 << w_grant : 4'b0000;
    assign w_data   = w_grant == 2'd0 ? in0 : w_grant == 2'd1 ? in1 : w_grant == 2'd2 ? in2 : in3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_out   <= '0;
            r_sel   <= 2'b00;
            r_ptr   <= 2'b00;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_out   <= w_data;
            r_sel   <= w_grant;
            r_ptr   <= w_grant + 2'd1;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out       = r_out;
    assign sel       = r_sel;
endmodule

// File: tb/tb_mux_4x1_rr.sv
// tb_mux_4x1_rr: directed scoreboard bench for mux_4x1_rr
module tb_mux_4x1_rr;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_valid = 4'b0000;
    logic [3:0] in_ready;
    logic [7:0] d [4];
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out;
    logic [1:0] sel;

    int total = 0;
    int bad = 0;
    logic [9:0] q[$];
    logic [1:0] m_ptr = 2'd0;
    logic       m_ov = 1'b0;

    always #5 clk = ~clk;

    mux_4x1_rr #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in0(d[0]), .in1(d[1]), .in2(d[2]), .in3(d[3]),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .sel(sel)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [2:0] pick(input logic [3:0] v, input logic [1:0] p);
        logic [1:0] i;
        for (int k = 0; k < 4; k++) begin
            i = p + 2'(k);
            if (v[i]) return {1'b1, i};
        end
        return 3'b000;
    endfunction

    // One clock: drive inputs, check outputs and in_ready against the model, advance model.
    task automatic cycle(input logic [3:0] v, input logic ro);
        logic       ld;
        logic [2:0] g;
        logic [3:0] er;
        in_valid  = v;
        out_ready = ro;
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov && q.size() > 0) chk("out_word", 32'({sel, out}), 32'(q[0]));
        ld = !rst && (!m_ov || ro);
        g  = pick(v, m_ptr);
        er = (ld && g[2]) ? 4'b0001 << g[1:0] : 4'b0000;
        chk("in_ready", 32'(in_ready), 32'(er));
        if (m_ov && ro && q.size() > 0) void'(q.pop_front());
        if (ld && g[2]) begin
            q.push_back({g[1:0], d[g[1:0]]});
            m_ptr = g[1:0] + 2'd1;
            m_ov  = 1'b1;
        end else if (m_ov && ro) begin
            m_ov = 1'b0;
        end
        if (rst) begin
            q.delete();
            m_ov  = 1'b0;
            m_ptr = 2'd0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
        @(negedge clk);
        // reset with all lanes valid
        cycle(4'b1111, 1'b1);
        cycle(4'b1111, 1'b1);
        rst = 1'b0;
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_ov", 32'(out_valid), 32'h0);
        // single lane 2
        d[2] = 8'hA5;
        cycle(4'b0100, 1'b1);
        chk("single_out", 32'(out), 32'hA5);
        chk("single_sel", 32'(sel), 32'h2);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
        // ptr now 3: lane 0 before lane 1
        d[2] = 8'h33;
        cycle(4'b0011, 1'b1);
        chk("wrap_sel0", 32'(sel), 32'h0);
        cycle(4'b0010, 1'b1);
        chk("wrap_sel1", 32'(sel), 32'h1);
        cycle(4'b0000, 1'b1);
        // reset, then round robin from lane 0
        rst = 1'b1;
        cycle(4'b0000, 1'b1);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) cycle(4'b1111, 1'b1);
        chk("rr_last_sel", 32'(sel), 32'h0);
        cycle(4'b0000, 1'b1);
        // backpressure: ptr=1, lanes 1 and 3
        cycle(4'b1010, 1'b1);
        cycle(4'b1010, 1'b0);
        chk("bp_out", 32'(out), 32'h22);
        cycle(4'b1010, 1'b0);
        cycle(4'b1010, 1'b1);
        chk("bp_sel3", 32'(sel), 32'h3);
        cycle(4'b0010, 1'b1);
        chk("bp_sel1", 32'(sel), 32'h1);
        cycle(4'b0000, 1'b1);
        // reset mid-stall discards held word
        cycle(4'b1000, 1'b1);
        cycle(4'b0000, 1'b0);
        rst = 1'b1;
        cycle(4'b1111, 1'b0);
        rst = 1'b0;
        chk("stall_rst_ov", 32'(out_valid), 32'h0);
        cycle(4'b1111, 1'b1);
        chk("post_rst_sel", 32'(sel), 32'h0);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_4x1_rr.md
Name: mux_4x1_rr

Overview:
Sequential 4-to-1 channel combiner. It is the gathering counterpart of the 1x4 demux routing blocks. Four independent valid/ready input lanes are arbitrated round-robin onto one registered output stream, and each output word is tagged with the 2-bit index of its source lane. Downstream logic can use that tag to re-split the stream with a 1x4 demux.

Parameters:
WIDTH, 8, data width of every lane and of the output.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  4  bit i: lane i presents a word
in_ready  output  4  bit i: lane i word accepted this cycle (combinational)
in0  input  WIDTH  lane 0 data
in1  input  WIDTH  lane 1 data
in2  input  WIDTH  lane 2 data
in3  input  WIDTH  lane 3 data
out_valid  output  1  output register holds a word
out_ready  input  1  downstream accepts word this cycle
out  output  WIDTH  output data (registered)
sel  output  2  source lane of current output word (registered)

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out=0, sel=2'b00, round-robin pointer ptr=0. in_ready is all zero during any cycle with rst=1. Reset mid-transfer discards the held word; no lane is accepted in that cycle.
- Load enable: load = !rst && (!out_valid || out_ready).
- Arbitration (combinational):
  - Search in_valid starting at index ptr, ascending, wrapping 3->0.
  - The first set bit is grant g.
  - in_ready = load ? one-hot(g) : 4'b0000. If no in_valid bit is set, in_ready = 0.
  - in_ready never depends on in_valid of a non-granted lane beyond the priority search. Exactly one in_ready bit is high at most.
- Transfer: lane g transfers when in_valid[g] && in_ready[g]. At that edge: out<=in_g, sel<=g, out_valid<=1, ptr<=(g+1) mod 4 (2-bit wrap).
- Output accept without new load (out_valid && out_ready && no transfer): out_valid<=0. out and sel keep their last values.
- Stall (out_valid && !out_ready): out, sel and out_valid hold stable; in_ready=0; ptr unchanged.
- Simultaneous accept+load: the old word leaves and the new word enters in the same edge, giving throughput 1 word/cycle.
- Latency: 1 cycle from input handshake to out_valid.
- Ptr updates only on a transfer. Idle cycles do not advance it.
- Fairness: with all four lanes continuously valid and out_ready=1, the grant order is 0,1,2,3,0,... and no lane waits more than 3 transfers.
- Inputs are not registered. Lanes must hold in_valid/data until ready per the standard valid/ready rule; the block does not check this.

Test Plan:
- Reset: assert rst for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out=0, sel=00. After release, the first grant is lane 0.
- Single lane: in_valid=0100, in2=8'hA5, out_ready=1 -> in_ready=0100 in that cycle. Next cycle out=A5, sel=10, out_valid=1. Then with in_valid=0 -> out_valid=0 one cycle later.
- Round-robin: in_valid=1111 held, in0..in3=11,22,33,44, out_ready=1 -> outputs 11/00, 22/01, 33/10, 44/11, 11/00 on consecutive cycles with no bubbles.
- Backpressure: lanes 1 and 3 valid, out_ready=0 after the first word -> out=in1, sel=01 held stable, in_ready=0000. On out_ready=1, the next word is lane 3 (sel=11), then lane 1.
- Pointer wrap/skip: ptr=3 after a lane-2 grant, in_valid=0011 -> lane 0 granted (not lane 1), then lane 1.
- Reset mid-stall: out_valid=1 with out_ready=0, pulse rst -> out_valid=0, ptr=0 next cycle. The held word is never delivered.
